// File: rtl/fetch_pkg.sv
// Shared types and constants for the LC-3 instruction-fetch sequencer.
// Used by fetch_sequencer and fetch_wait_timer.
package fetch_pkg;

  typedef enum logic [2:0] {
    HALTED = 3'd0,
    F1     = 3'd1,
    F2     = 3'd2,
    F3     = 3'd3,
    ISSUE  = 3'd4,
    REDIR  = 3'd5,
    PAUSED = 3'd6
  } fetch_state_e;

  localparam logic [1:0] PCMUX_INC  = 2'b00;
  localparam logic [1:0] PCMUX_ADDR = 2'b01;
  localparam logic [1:0] PCMUX_BUS  = 2'b10;

  // Every state that is actively working on an instruction.
  function automatic logic state_is_busy(input fetch_state_e s);
    return (s != HALTED) && (s != PAUSED);
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Loadable down-counter that flags the last F2 cycle of a fixed-latency
// memory read. load_i reloads LATENCY; last_o is high while enabled at count 1.
module fetch_wait_timer #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic last_o
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = en_i && (cnt_q == ONE);

endmodule

// File: rtl/fetch_sequencer.sv
// LC-3 instruction-fetch controller: F1/F2/F3 fetch, ISSUE, REDIR, PAUSED.
// Optional macro FETCH_MEM_RDY_EN makes F2 wait on mem_rdy instead of a timer.
// Handshake: exec_done is sampled only in ISSUE; redirect_valid, redirect_sel
// and pause_req are meaningful only in that same cycle and are captured then.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Run,
  input  logic         Continue,
  input  logic         mem_rdy,
  input  logic         exec_done,
  input  logic         redirect_valid,
  input  logic         redirect_sel,
  input  logic         pause_req,
  output logic [1:0]   PCMUX,
  output logic         LD_PC,
  output logic         LD_MAR,
  output logic         LD_MDR,
  output logic         LD_IR,
  output logic         GatePC,
  output logic         GateMDR,
  output logic         Mem_OE,
  output logic         ir_valid,
  output logic         busy,
  output logic [15:0]  fetch_count,
  output fetch_state_e dbg_state
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic         continue_q;
  logic         continue_d;
  logic         pause_q;
  logic         pause_d;
  logic         sel_q;
  logic         sel_d;
  logic [15:0]  fetch_count_q;
  logic [15:0]  fetch_count_d;
  logic         f2_done;
  logic         issue_accept;
  logic         continue_rise;

  assign issue_accept  = (state_q == ISSUE) && exec_done;
  assign continue_rise = Continue && !continue_q;

`ifdef FETCH_MEM_RDY_EN
  localparam int unused_latency = MEM_LATENCY;
  assign f2_done = mem_rdy;
`else
  logic unused_mem_rdy;
  assign unused_mem_rdy = mem_rdy;

  // F2 is only ever entered from F1, so loading in F1 reloads on every entry.
  fetch_wait_timer #(
    .LATENCY (MEM_LATENCY)
  ) u_wait_timer (
    .clk    (Clk),
    .rst    (Reset),
    .load_i (state_q == F1),
    .en_i   (state_q == F2),
    .last_o (f2_done)
  );
`endif

  // State register and the small pieces of captured context.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= HALTED;
      continue_q    <= 1'b0;
      pause_q       <= 1'b0;
      sel_q         <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      continue_q    <= continue_d;
      pause_q       <= pause_d;
      sel_q         <= sel_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HALTED: if (Run) state_d = F1;
      F1:     state_d = F2;
      F2:     if (f2_done) state_d = F3;
      F3:     state_d = ISSUE;
      ISSUE: begin
        if (exec_done) begin
          if (redirect_valid) begin
            state_d = REDIR;
          end else if (pause_req) begin
            state_d = PAUSED;
          end else begin
            state_d = F1;
          end
        end
      end
      REDIR:  state_d = pause_q ? PAUSED : F1;
      PAUSED: if (continue_rise) state_d = F1;
      default: state_d = HALTED;
    endcase
  end

  // Continue_q tracks every cycle, so a level already high on PAUSED entry
  // never looks like a rising edge.
  always_comb begin
    continue_d    = Continue;
    pause_d       = pause_q;
    sel_d         = sel_q;
    fetch_count_d = fetch_count_q;
    if (issue_accept) begin
      pause_d = pause_req;
      sel_d   = redirect_sel;
    end
    if (state_q == F3) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  // Output decode.
  always_comb begin
    PCMUX    = PCMUX_INC;
    LD_PC    = 1'b0;
    LD_MAR   = 1'b0;
    LD_MDR   = 1'b0;
    LD_IR    = 1'b0;
    GatePC   = 1'b0;
    GateMDR  = 1'b0;
    Mem_OE   = 1'b0;
    ir_valid = 1'b0;
    case (state_q)
      F1: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
        PCMUX  = PCMUX_INC;
      end
      F2: begin
        Mem_OE = 1'b1;
        LD_MDR = f2_done;
      end
      F3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      ISSUE: ir_valid = 1'b1;
      REDIR: begin
        LD_PC = 1'b1;
        PCMUX = sel_q ? PCMUX_BUS : PCMUX_ADDR;
      end
      default: begin
        PCMUX = PCMUX_INC;
      end
    endcase
  end

  assign busy        = state_is_busy(state_q);
  assign fetch_count = fetch_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected per-cycle output rows are queued
// by the driver and compared by a monitor whenever the DUT is busy.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int MEM_LAT = 2;
  localparam int W       = 26;
`ifdef FETCH_MEM_RDY_EN
  localparam bit RDY_MODE = 1'b1;
`else
  localparam bit RDY_MODE = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Run;
  logic         Continue;
  logic         mem_rdy;
  logic         exec_done;
  logic         redirect_valid;
  logic         redirect_sel;
  logic         pause_req;
  logic [1:0]   PCMUX;
  logic         LD_PC, LD_MAR, LD_MDR, LD_IR;
  logic         GatePC, GateMDR, Mem_OE, ir_valid, busy;
  logic [15:0]  fetch_count;
  fetch_state_e dbg_state;

  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_cnt;
  int           tests_run    = 0;
  int           tests_failed = 0;

  fetch_sequencer #(.MEM_LATENCY(MEM_LAT)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Run            (Run),
    .Continue       (Continue),
    .mem_rdy        (mem_rdy),
    .exec_done      (exec_done),
    .redirect_valid (redirect_valid),
    .redirect_sel   (redirect_sel),
    .pause_req      (pause_req),
    .PCMUX          (PCMUX),
    .LD_PC          (LD_PC),
    .LD_MAR         (LD_MAR),
    .LD_MDR         (LD_MDR),
    .LD_IR          (LD_IR),
    .GatePC         (GatePC),
    .GateMDR        (GateMDR),
    .Mem_OE         (Mem_OE),
    .ir_valid       (ir_valid),
    .busy           (busy),
    .fetch_count    (fetch_count),
    .dbg_state      (dbg_state)
  );

  // Clock / watchdog
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] row(input logic [1:0] pcm, input logic ldpc,
      input logic ldmar, input logic ldmdr, input logic ldir, input logic gpc,
      input logic gmdr, input logic oe, input logic irv, input logic [15:0] cnt);
    return {pcm, ldpc, ldmar, ldmdr, ldir, gpc, gmdr, oe, irv, cnt};
  endfunction

  function automatic logic [W-1:0] cur_vec();
    return {PCMUX, LD_PC, LD_MAR, LD_MDR, LD_IR, GatePC, GateMDR, Mem_OE,
            ir_valid, fetch_count};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: one row per busy cycle, sampled on the falling edge.
  always @(negedge Clk) begin
    if (!Reset && busy) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_busy: got %h required idle (t=%0t)", cur_vec(), $time);
      end else begin
        check("cycle_row", cur_vec(), exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_run();
    Run = 1'b1;
    step();
    Run = 1'b0;
  endtask

  // Entered in the F1 cycle; leaves in the cycle after the ISSUE/REDIR exit.
  task automatic txn(input int f2_req, input int n_issue, input bit redir,
                     input bit sel, input bit pause, input bit noise);
    int f2;
    f2 = RDY_MODE ? f2_req : MEM_LAT;
    exp_q.push_back(row(2'b00, 1, 1, 0, 0, 1, 0, 0, 0, exp_cnt));
    for (int i = 0; i < f2; i++)
      exp_q.push_back(row(2'b00, 0, 0, (i == f2 - 1), 0, 0, 0, 1, 0, exp_cnt));
    exp_q.push_back(row(2'b00, 0, 0, 0, 1, 0, 1, 0, 0, exp_cnt));
    exp_cnt = exp_cnt + 16'd1;
    for (int i = 0; i < n_issue; i++)
      exp_q.push_back(row(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, exp_cnt));
    if (redir)
      exp_q.push_back(row(sel ? 2'b10 : 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, exp_cnt));

    step();
    for (int i = 0; i < f2; i++) begin
      mem_rdy = RDY_MODE ? (i == f2 - 1) : (i == 0);
      if (noise && i == 0) begin
        exec_done = 1'b1;
        Run       = 1'b1;
      end
      step();
      exec_done = 1'b0;
      Run       = 1'b0;
    end
    mem_rdy = 1'b0;
    step();
    for (int i = 1; i < n_issue; i++) step();
    exec_done      = 1'b1;
    redirect_valid = redir;
    redirect_sel   = sel;
    pause_req      = pause;
    step();
    exec_done      = 1'b0;
    redirect_valid = 1'b0;
    redirect_sel   = 1'b0;
    pause_req      = 1'b0;
    if (redir) step();
  endtask

  task automatic pause_chk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check("paused_outputs", cur_vec(), row(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, exp_cnt));
      check_bit("paused_busy", busy, 1'b0);
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic resume();
    Continue = 1'b0;
    pause_chk(1);
    Continue = 1'b1;
    step();
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0; mem_rdy = 1'b0;
    exec_done = 1'b0; redirect_valid = 1'b0; redirect_sel = 1'b0; pause_req = 1'b0;
    exp_cnt = 16'h0000;
    #3;
    check("reset_outputs", cur_vec(), '0);
    check_bit("reset_busy", busy, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Basic fetches, redirects via bus and address adder, spurious inputs.
    start_run();
    txn(6, 3, 0, 0, 0, 0);
    txn(6, 1, 1, 1, 0, 0);
    txn(6, 2, 1, 0, 0, 1);

    // Pause with Continue already high: must fall and rise again.
    Continue = 1'b1;
    txn(6, 1, 0, 0, 1, 0);
    pause_chk(3);
    resume();

    // Redirect combined with pause.
    txn(6, 1, 1, 0, 1, 0);
    pause_chk(2);
    resume();
    txn(6, 1, 0, 0, 0, 0);

    // Reset in the first F2 cycle.
    exp_q.push_back(row(2'b00, 1, 1, 0, 0, 1, 0, 0, 0, exp_cnt));
    exp_q.push_back(row(2'b00, 0, 0, 0, 0, 0, 0, 1, 0, exp_cnt));
    step();
    @(negedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    check("async_reset_outputs", cur_vec(), '0);
    check_bit("async_reset_busy", busy, 1'b0);
    exp_cnt = 16'h0000;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    start_run();
    txn(6, 1, 0, 0, 0, 0);

    // Back to HALTED, preload the count and wrap it.
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    force dut.fetch_count_q = 16'hFFFF;
    step();
    release dut.fetch_count_q;
    exp_cnt = 16'hFFFF;
    step();
    check("preload_count", {10'b0, fetch_count}, {10'b0, exp_cnt});
    start_run();
    txn(6, 2, 0, 0, 1, 0);
    pause_chk(1);

    repeat (3) step();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL leftover_rows: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
